imm_chunker: RTL and testbench

- Narrows an 8-bit constant into a most-significant-first stream of 3-bit aux fields.
- This is the inverse of the datapath's 3-bit-to-8-bit immediate extender: a receiver computing acc = (acc << 3) | aux over the stream rebuilds the original value.
- Sits on the constant-load path ahead of ID. Leading all-zero chunks are suppressed, so any value 0..7 costs exactly one field, which the extender widens back unchanged.

---
 rtl/imm_chunker_pkg.sv | 35 +++
 rtl/imm_chunker.sv | 86 ++++++++
 tb/tb_imm_chunker.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/imm_chunker_pkg.sv
// Shared definitions for the immediate chunker and any assembler-side model
// that needs to predict how many aux fields a constant will occupy.
//   DATA_W      width of the constant being split
//   AUX_W       width of one emitted aux field
//   NCHUNK      fields needed for a full-width constant
//   chunk_idx_t chunk position, 2 = top (zero-padded) field, 0 = low field
//   state_t     controller state
//   first_chunk index of the first non-suppressed field of a value
package imm_chunker_pkg;

    localparam int DATA_W = 8;
    localparam int AUX_W  = 3;
    localparam int NCHUNK = (DATA_W + AUX_W - 1) / AUX_W;

    typedef logic [1:0] chunk_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Leading all-zero fields are skipped; a value of 0 still costs one field.
    function automatic chunk_idx_t first_chunk(input logic [DATA_W-1:0] value);
        chunk_idx_t idx;
        if (value[7:6] != 2'b00) begin
            idx = 2'd2;
        end else if (value[5:3] != 3'b000) begin
            idx = 2'd1;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

endpackage

// File: rtl/imm_chunker.sv
// Splits an 8-bit constant into a most-significant-first stream of 3-bit aux
// fields, suppressing leading zero fields. A receiver doing
// acc = (acc << 3) | aux over the stream rebuilds the value.
// Ports:
//   clk, reset               clock and synchronous active-high reset
//   in_valid/in_ready        input handshake, in_value is the constant
//   out_valid/out_ready      output handshake
//   out_aux                  current field
//   out_last                 current field is bits [2:0]
//   out_index                field position (2, 1, 0)
//   busy                     a value is held and not yet fully emitted
module imm_chunker
    import imm_chunker_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AUX_W-1:0]  out_aux,
    output logic              out_last,
    output logic [1:0]        out_index,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] val_q, val_d;
    chunk_idx_t        idx_q, idx_d;
    logic              accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            val_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        val_d     = val_q;
        idx_d     = idx_q;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_aux   = '0;
        out_last  = 1'b0;
        out_index = '0;

        if (state_q == SEND) begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_index = idx_q;
            out_last  = (idx_q == 2'd0);
            case (idx_q)
                2'd2:    out_aux = {1'b0, val_q[7:6]};
                2'd1:    out_aux = val_q[5:3];
                2'd0:    out_aux = val_q[2:0];
                default: out_aux = '0;
            endcase
        end

        // out_ready -> in_ready is combinational so a new value can load on
        // the same edge the last field leaves, with no bubble.
        in_ready = (state_q == IDLE) || (out_valid && out_ready && out_last);
        accept   = in_valid && in_ready;

        if (accept) begin
            val_d   = in_value;
            idx_d   = first_chunk(in_value);
            state_d = SEND;
        end else if (state_q == SEND && out_ready) begin
            if (idx_q != 2'd0) begin
                idx_d = idx_q - 2'd1;
            end else begin
                state_d = IDLE;
            end
        end
    end

endmodule

// File: tb/tb_imm_chunker.sv
module tb_imm_chunker;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_value;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_aux;
    logic       out_last;
    logic [1:0] out_index;
    logic       busy;

    imm_chunker dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_aux   (out_aux),
        .out_last  (out_last),
        .out_index (out_index),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [2:0] aux;
        logic [1:0] idx;
        logic       last;
        int         cyc;
    } obs_t;

    obs_t obs[$];

    typedef struct {
        logic [7:0] value;
        int         n;
        logic [2:0] a0;
        logic [2:0] a1;
        logic [2:0] a2;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Record every output transfer; verify fields hold while stalled.
    logic       prev_stall = 1'b0;
    logic [2:0] prev_aux;
    logic [1:0] prev_idx;
    logic       prev_last;
    always @(negedge clk) begin
        obs_t o;
        if (!reset && prev_stall) begin
            check("stall_valid", {31'b0, out_valid}, 32'd1);
            check("stall_fields", {26'b0, out_aux, out_index, out_last},
                  {26'b0, prev_aux, prev_idx, prev_last});
        end
        if (!reset && out_valid && out_ready) begin
            o.aux  = out_aux;
            o.idx  = out_index;
            o.last = out_last;
            o.cyc  = cyc;
            obs.push_back(o);
        end
        prev_stall = !reset && out_valid && !out_ready;
        prev_aux   = out_aux;
        prev_idx   = out_index;
        prev_last  = out_last;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            failures++;
            $display("FAIL %s_timeout: busy stuck at %0b expected 0", name, busy);
        end
    endtask

    // Compare recorded stream against expected fields (emission order).
    task automatic check_stream(input string name, input logic [7:0] value, input int n,
                                input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
        logic [2:0] exp_a[3];
        logic [7:0] acc;
        exp_a[0] = a0;
        exp_a[1] = a1;
        exp_a[2] = a2;
        acc = 8'h00;
        check({name, "_count"}, obs.size(), n);
        for (int k = 0; k < n && k < obs.size(); k++) begin
            check({name, "_aux"}, {29'b0, obs[k].aux}, {29'b0, exp_a[k]});
            check({name, "_idx"}, {30'b0, obs[k].idx}, n - 1 - k);
            check({name, "_last"}, {31'b0, obs[k].last}, (k == n - 1) ? 32'd1 : 32'd0);
            acc = (acc << 3) | {5'b0, obs[k].aux};
        end
        check({name, "_rebuilt"}, {24'b0, acc}, {24'b0, value});
        obs.delete();
    endtask

    task automatic send_one(input logic [7:0] v);
        in_valid = 1'b1;
        in_value = v;
        @(negedge clk);
        check("accept_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h05, 1, 3'd5, 3'd0, 3'd0};
        vecs[1] = '{8'hB7, 3, 3'd2, 3'd6, 3'd7};
        vecs[2] = '{8'h2A, 2, 3'd5, 3'd2, 3'd0};
        vecs[3] = '{8'h00, 1, 3'd0, 3'd0, 3'd0};
        vecs[4] = '{8'h40, 3, 3'd1, 3'd0, 3'd0};
        vecs[5] = '{8'h08, 2, 3'd1, 3'd0, 3'd0};
        vecs[6] = '{8'hFF, 3, 3'd3, 3'd7, 3'd7};
        vecs[7] = '{8'h07, 1, 3'd7, 3'd0, 3'd0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_value  = 8'h00;
        out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_fields", {26'b0, out_aux, out_index, out_last}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        obs.delete();

        // Table: single values, consumer always ready.
        for (int i = 0; i < 8; i++) begin
            send_one(vecs[i].value);
            wait_idle("vec");
            check("vec_idle_valid", {31'b0, out_valid}, 32'd0);
            check_stream($sformatf("vec%0d", i), vecs[i].value, vecs[i].n,
                         vecs[i].a0, vecs[i].a1, vecs[i].a2);
            tick();
        end

        // Backpressure: out_ready 1,0,0,1,1 after accept.
        send_one(8'hB7);
        out_ready = 1'b1; tick();
        out_ready = 1'b0; tick();
        out_ready = 1'b0; tick();
        out_ready = 1'b1; tick();
        out_ready = 1'b1;
        wait_idle("bp");
        check_stream("bp", 8'hB7, 3, 3'd2, 3'd6, 3'd7);
        tick();

        // Back-to-back: 0xC0 waits while 0x2A streams, loads on its last field.
        in_valid = 1'b1;
        in_value = 8'h2A;
        tick();
        in_value = 8'hC0;
        @(negedge clk);
        check("b2b_hold_ready", {31'b0, in_ready}, 32'd0);
        tick();
        @(negedge clk);
        check("b2b_last_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        wait_idle("b2b");
        check("b2b_span", obs.size() == 5 ? obs[4].cyc - obs[0].cyc : -1, 4);
        begin
            obs_t first3[$];
            for (int k = 0; k < 2 && k < obs.size(); k++) begin
                check("b2b_a_aux", {29'b0, obs[k].aux}, (k == 0) ? 32'd5 : 32'd2);
                check("b2b_a_idx", {30'b0, obs[k].idx}, 1 - k);
            end
            for (int k = 2; k < obs.size(); k++) first3.push_back(obs[k]);
            obs = first3;
        end
        check_stream("b2b_b", 8'hC0, 3, 3'd3, 3'd0, 3'd0);
        tick();

        // Reset mid-stream discards the rest of 0xB7.
        send_one(8'hB7);
        @(negedge clk);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        tick();
        tick();
        check("mid_rst_count", obs.size(), 1);
        if (obs.size() > 0) check("mid_rst_aux", {29'b0, obs[0].aux}, 32'd2);
        obs.delete();
        send_one(8'h07);
        wait_idle("post_rst");
        check_stream("post_rst", 8'h07, 1, 3'd7, 3'd0, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: run did not finish, expected completion");
        $fatal(1);
    end

endmodule
